bcd_a_binario: RTL and testbench
================================

Name: bcd_a_binario

Overview:
- Sequential BCD-to-binary converter, the inverse of the team's binary-to-BCD display decoder.
- Accepts DIGITS packed BCD digits (thousands..units), e.g. from switch or keypad entry, and produces the OUT_W-bit binary value.
- Iterative multiply-by-10-and-add datapath, one digit per clock, start/busy/done handshake.
- Invalid-digit and overflow detection so downstream logic never consumes a bad value.

Parameters:
- DIGITS, 4, number of BCD digits in bcd_in (min 1).
- OUT_W, 10, width of bin_out; maximum representable value MAXV = 2^OUT_W-1 (1023 at default).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request conversion; honoured only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD; nibble [3:0] = units, [7:4] = tens, [11:8] = hundreds, [15:12] = thousands.
- busy  output  1  high while converting (state CONV).
- done  output  1  one-cycle pulse, result valid.
- bin_out  output  OUT_W  converted value, held until next done.
- err_digit  output  1  a captured nibble was >9; held with bin_out.
- err_ovf  output  1  value exceeded MAXV, result saturated; held with bin_out.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state=IDLE; busy=0, done=0, bin_out=0, err_digit=0, err_ovf=0; internal accumulator, digit counter and captured digits cleared. Reset wins over every other input, including mid-conversion; an aborted conversion produces no done.
- FSM states:
  - IDLE: start=1 at an edge -> capture bcd_in into shadow register, acc=0, cnt=0, invalid flag = OR over all nibbles of (nibble>9), go to CONV. start=0 -> stay.
  - CONV: busy=1. Each edge: acc = acc*10 + digit[DIGITS-1-cnt] (most significant first), cnt++. After DIGITS updates go to DONE.
  - DONE: done=1 for exactly this cycle; bin_out, err_digit and err_ovf update on the edge entering DONE; next edge -> IDLE.
- Latency: start sampled at edge k -> busy high cycles k+1..k+DIGITS -> done high in cycle k+DIGITS+1 (DIGITS+1 cycles; 5 at default). Next start accepted at edge k+DIGITS+2 at the earliest.
- start while in CONV or DONE is ignored (not queued). bcd_in changes after capture have no effect.
- Accumulator width: ceil(log2(10^DIGITS)) bits (14 at default), so no internal wrap occurs. Clamp digits >9 to 9 inside the multiply only to keep the width bound; the result is discarded anyway.
- Result selection, in priority order:
  - invalid -> bin_out=0, err_digit=1, err_ovf=0.
  - else acc>MAXV -> bin_out=MAXV, err_ovf=1, err_digit=0.
  - else bin_out=acc[OUT_W-1:0], both flags 0.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset, then start with bcd_in=16'h0999 -> busy high 4 cycles, done pulse on the 5th cycle after start, bin_out=999, both flags 0; bin_out holds 999 for 10 further idle cycles.
- bcd_in=16'h1023 -> bin_out=1023, flags 0. bcd_in=16'h1024 -> bin_out=1023, err_ovf=1. bcd_in=16'h9999 -> bin_out=1023, err_ovf=1.
- bcd_in=16'h0A05 -> bin_out=0, err_digit=1, err_ovf=0. bcd_in=16'hF999 (invalid and overflowing) -> err_digit=1, err_ovf=0, bin_out=0.
- start=1 with 16'h0042, then keep start high and change bcd_in to 16'h0777 during CONV -> exactly one done, bin_out=42. Continued start high is accepted on the first IDLE edge after DONE, giving a second result of 777.
- Start 16'h0500, assert rst for 1 cycle in the 2nd CONV cycle -> no done, all outputs 0, busy 0 the cycle after reset. A new start with 16'h0007 -> bin_out=7.
- Sweep 0000..1023 in BCD, each start issued right after the previous done -> bin_out equals the decimal value each time; exhaustive compare against the binary-to-BCD decoder output (round-trip).

Source files
------------

// File: rtl/bcd_a_binario.sv
// ============================================================================
// bcd_a_binario : sequential BCD-to-binary converter (x10-and-add, 1 digit/clk)
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_a_binario #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                busy,
  output logic                done,
  output logic [OUT_W-1:0]    bin_out,
  output logic                err_digit,
  output logic                err_ovf
);

  localparam int ACC_W = $clog2(10**DIGITS);
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CMP_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);
  localparam logic [OUT_W-1:0] MAXV     = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                invalid_q, invalid_d;
  logic [OUT_W-1:0]    bin_out_q, bin_out_d;
  logic                err_digit_q, err_digit_d;
  logic                err_ovf_q, err_ovf_d;

  logic                invalid_scan;
  logic [3:0]          digit_raw;
  logic [3:0]          digit_clamp;
  logic [ACC_W-1:0]    acc_next;
  logic [CMP_W-1:0]    acc_ext;

  always_comb begin
    invalid_scan = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) invalid_scan = 1'b1;
    end

    // Most significant digit first; clamping keeps acc inside ACC_W bits.
    digit_raw   = shadow_q[4*(DIGITS-1-int'(cnt_q)) +: 4];
    digit_clamp = (digit_raw > 4'd9) ? 4'd9 : digit_raw;
    acc_next    = acc_q * ACC_W'(10) + ACC_W'(digit_clamp);
    acc_ext     = CMP_W'(acc_next);

    state_d     = state_q;
    shadow_d    = shadow_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    invalid_d   = invalid_q;
    bin_out_d   = bin_out_q;
    err_digit_d = err_digit_q;
    err_ovf_d   = err_ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d  = bcd_in;
          acc_d     = '0;
          cnt_d     = '0;
          invalid_d = invalid_scan;
          state_d   = CONV;
        end
      end
      CONV: begin
        acc_d = acc_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = DONE;
          if (invalid_q) begin
            bin_out_d   = '0;
            err_digit_d = 1'b1;
            err_ovf_d   = 1'b0;
          end else if (acc_ext > CMP_W'(MAXV)) begin
            bin_out_d   = MAXV;
            err_digit_d = 1'b0;
            err_ovf_d   = 1'b1;
          end else begin
            bin_out_d   = acc_ext[OUT_W-1:0];
            err_digit_d = 1'b0;
            err_ovf_d   = 1'b0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      invalid_q   <= 1'b0;
      bin_out_q   <= '0;
      err_digit_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      invalid_q   <= invalid_d;
      bin_out_q   <= bin_out_d;
      err_digit_q <= err_digit_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign busy      = (state_q == CONV);
  assign done      = (state_q == DONE);
  assign bin_out   = bin_out_q;
  assign err_digit = err_digit_q;
  assign err_ovf   = err_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_a_binario.sv
// ============================================================================
// tb_bcd_a_binario : self-checking bench for bcd_a_binario (DIGITS=4, OUT_W=10)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bcd_a_binario;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bcd_in = 16'h0000;
  logic        busy;
  logic        done;
  logic [9:0]  bin_out;
  logic        err_digit;
  logic        err_ovf;

  int n_pass = 0;
  int n_total = 0;

  bcd_a_binario #(.DIGITS(4), .OUT_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bcd_in    (bcd_in),
    .busy      (busy),
    .done      (done),
    .bin_out   (bin_out),
    .err_digit (err_digit),
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    int          exp_bin;
    bit          exp_ed;
    bit          exp_eo;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Decimal reference: interpret nibbles as decimal digits, then apply error rules.
  task automatic ref_model(input logic [15:0] b, output int v, output bit ed, output bit eo);
    int d;
    v = 0; ed = 0; eo = 0;
    for (int i = 3; i >= 0; i--) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) ed = 1;
      v = v * 10 + d;
    end
    if (ed) v = 0;
    else if (v > 1023) begin v = 1023; eo = 1; end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Issue one conversion from IDLE; returns result at the done cycle and latency/busy counts.
  task automatic convert(input logic [15:0] b, output int ob, output bit oed, output bit oeo,
                         output int lat, output int nbusy);
    bcd_in = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    lat    = 1;
    nbusy  = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      tick();
      lat++;
    end
    if (!done) check("done_timeout", 0, 1);
    ob  = int'(bin_out);
    oed = err_digit;
    oeo = err_ovf;
    tick();
  endtask

  vec_t vecs[8];

  initial begin
    int ob, lat, nb, rv, nd, cyc1, cyc2, val1, val2;
    bit oed, oeo, red, reo, done_seen;
    logic [15:0] rb;

    vecs[0] = '{16'h0999,  999, 1'b0, 1'b0};
    vecs[1] = '{16'h1023, 1023, 1'b0, 1'b0};
    vecs[2] = '{16'h1024, 1023, 1'b0, 1'b1};
    vecs[3] = '{16'h9999, 1023, 1'b0, 1'b1};
    vecs[4] = '{16'h0A05,    0, 1'b1, 1'b0};
    vecs[5] = '{16'hF999,    0, 1'b1, 1'b0};
    vecs[6] = '{16'h0000,    0, 1'b0, 1'b0};
    vecs[7] = '{16'h0001,    1, 1'b0, 1'b0};

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_bin", int'(bin_out), 0);
    check("rst_edig", int'(err_digit), 0);
    check("rst_eovf", int'(err_ovf), 0);
    tick();

    // First conversion: latency, busy length and hold behaviour
    convert(16'h0999, ob, oed, oeo, lat, nb);
    check("lat_0999", lat, 5);
    check("busy_cycles_0999", nb, 4);
    check("bin_0999", ob, 999);
    for (int i = 0; i < 10; i++) begin
      check("hold_999", int'(bin_out), 999);
      check("hold_nodone", int'(done), 0);
      tick();
    end

    foreach (vecs[i]) begin
      convert(vecs[i].bcd, ob, oed, oeo, lat, nb);
      check($sformatf("tbl_bin_%h", vecs[i].bcd), ob, vecs[i].exp_bin);
      check($sformatf("tbl_edig_%h", vecs[i].bcd), int'(oed), int'(vecs[i].exp_ed));
      check($sformatf("tbl_eovf_%h", vecs[i].bcd), int'(oeo), int'(vecs[i].exp_eo));
      check($sformatf("tbl_lat_%h", vecs[i].bcd), lat, 5);
    end

    // start held high with bcd_in changed mid-conversion
    bcd_in = 16'h0042;
    start  = 1'b1;
    tick();
    bcd_in = 16'h0777;
    nd = 0; cyc1 = -1; cyc2 = -1; val1 = -1; val2 = -1;
    for (int c = 1; c <= 11; c++) begin
      if (done) begin
        nd++;
        if (nd == 1) begin cyc1 = c; val1 = int'(bin_out); end
        else begin cyc2 = c; val2 = int'(bin_out); end
      end
      if (c == 11) start = 1'b0;
      tick();
    end
    check("hold_start_ndone", nd, 2);
    check("hold_start_cyc1", cyc1, 5);
    check("hold_start_val1", val1, 42);
    check("hold_start_cyc2", cyc2, 11);
    check("hold_start_val2", val2, 777);
    tick();

    // Reset in the second CONV cycle aborts the conversion
    bcd_in = 16'h0500;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    rst    = 1'b1;
    tick();
    rst    = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_bin", int'(bin_out), 0);
    check("abort_edig", int'(err_digit), 0);
    check("abort_eovf", int'(err_ovf), 0);
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) done_seen = 1;
      tick();
    end
    check("abort_no_done", int'(done_seen), 0);
    convert(16'h0007, ob, oed, oeo, lat, nb);
    check("after_abort_bin", ob, 7);

    // Random BCD words (valid and invalid) against the decimal reference
    for (int i = 0; i < 200; i++) begin
      if (i % 2 == 0) rb = to_bcd(int'($urandom_range(0, 9999)));
      else rb = 16'($urandom);
      ref_model(rb, rv, red, reo);
      convert(rb, ob, oed, oeo, lat, nb);
      if (ob != rv || oed != red || oeo != reo || lat != 5) begin
        check($sformatf("rand_%h_bin", rb), ob, rv);
        check($sformatf("rand_%h_edig", rb), int'(oed), int'(red));
        check($sformatf("rand_%h_eovf", rb), int'(oeo), int'(reo));
        check($sformatf("rand_%h_lat", rb), lat, 5);
      end else begin
        check("rand_ok", 1, 1 - int'(ob != rv));
      end
    end

    // Round-trip sweep 0..1023
    for (int v = 0; v < 1024; v++) begin
      convert(to_bcd(v), ob, oed, oeo, lat, nb);
      check($sformatf("sweep_%0d", v), ob + 2048 * int'(oed) + 4096 * int'(oeo), v);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
